step_capture: RTL and testbench
===============================

# step_capture

Receiver for the step/dir motor-command interface. It decodes an external step/dir pulse stream back into a signed 32-bit position and a step-period measurement. It sits on the input side of the motion core, either as loopback verification of our own step generator or to follow an external controller. Asynchronous pins are synchronized, glitch-filtered and checked for direction-setup violations.

## Interface
Parameters:
- FILTER_LEN, 4: consecutive synchronized cycles a new step level must persist before it is accepted (min 2).
- DIR_SETUP, 16: minimum synchronized cycles dir must be stable before an accepted step rising edge.
- PERIOD_W, 24: width of the period counter and output.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- step_in  in  1  asynchronous step pin
- dir_in  in  1  asynchronous dir pin; 0 = +1, 1 = -1
- set_position  in  1  load position from data_in
- data_in  in  32  signed position load value
- clear_err  in  1  clears sticky error flags
- position  out  32  signed step count
- step_strobe  out  1  one-cycle pulse per counted step
- step_dir  out  1  dir used for the last counted step
- period  out  PERIOD_W  clk cycles between the last two counted steps
- period_valid  out  1  period holds a real measurement
- stalled  out  1  period counter saturated
- dir_err  out  1  sticky: step accepted with dir stable < DIR_SETUP
- glitch_err  out  1  sticky: a step transition was rejected by the filter

## Operation
- Sync: step_in and dir_in each pass through two flops (s1, s2).
- Filter state machine, two states (LOW, HIGH), plus counter fcnt:
  - fcnt increments each cycle s2 differs from the state.
  - A flip occurs when s2 differs and fcnt == FILTER_LEN-1; fcnt then clears.
  - If s2 matches the state while fcnt != 0: fcnt clears and glitch_err sets.
- A LOW→HIGH flip is a step event. HIGH→LOW flips are never counted.
- dir_stable counts cycles since dir s2 last changed, saturating at DIR_SETUP.
- On a step event:
  - position ± 1 according to dir s2 (0 → +1, 1 → -1), with 32-bit wrap.
  - step_dir <= dir s2; step_strobe = 1.
  - dir_err sets if dir_stable < DIR_SETUP. The step is still counted.
- Period counter pcnt increments each cycle, saturating at 2^PERIOD_W-1.
  - On a step event: period <= min(pcnt+1, max), then pcnt <= 0.
  - period_valid sets on the second step event after reset/set_position.
- stalled = (pcnt == max). When stalled, period_valid clears and period holds its last value.
- set_position:
  - position <= data_in; pcnt <= 0; period_valid <= 0.
  - Takes priority over a simultaneous step event: that step is not counted, no strobe, no period update.
  - The filter state still flips, and dir_err is not evaluated for the dropped step.
- clear_err clears both sticky flags. A simultaneous new error wins (flag stays set).

## Timing
- Reset values:
  - Sync flops of step_in = 1, filter state = HIGH, so a line already high at reset release is not counted.
  - Sync flops of dir_in = 0, dir_stable = 0, fcnt = 0.
  - All outputs 0.
- Step latency: step_in first sampled high at edge k, stable → step_strobe and position update at edge k+FILTER_LEN+1.
- Falling edge is accepted at the same latency, with no output effect.
- Minimum countable pulse: FILTER_LEN cycles high and FILTER_LEN cycles low.
- All outputs are registered except stalled, which decodes registered pcnt.

## Structure
- Sub-module sync_filter: 2-flop synchronizer, FILTER_LEN filter, level output, rise/fall pulses and glitch output. Instantiated for step_in.
- dir_in uses only the synchronizer part, via a parameter that bypasses the filter.
- The shared motion package holds the dir polarity constants (DIR_POS = 0, DIR_NEG = 1) used by both generator and receiver.

## Test plan
1. Reset with step_in=1, then hold high 50 cycles → no strobe, position 0.
2. FILTER_LEN=4, dir=0 stable 40 cycles; step_in low 10 cycles, high 10 cycles, first sampled high at edge k → strobe at edge k+5, position 1, step_dir 0.
3. Three steps 300 cycles apart with dir=1 → position -3, period 300, period_valid 1 after the second step.
4. Step_in high pulse of 2 cycles → not counted, glitch_err 1; clear_err → 0.
5. dir toggles 5 cycles before an accepted step edge (DIR_SETUP=16) → step counted with the new dir, dir_err 1.
6. PERIOD_W=8, no steps for 300 cycles → stalled 1, period_valid 0. set_position with data_in=1000 coincident with a step event → position 1000, no strobe.

Source files
------------

// File: rtl/step_capture_pkg.sv
// Shared motion definitions for the step/dir command interface.
// Direction polarity is common to the step generator and this receiver.
package step_capture_pkg;

    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

    localparam logic [0:0] FILT_LOW  = 1'b0;
    localparam logic [0:0] FILT_HIGH = 1'b1;

    function automatic logic signed [31:0] step_delta(input logic dir);
        return (dir == DIR_NEG) ? -32'sd1 : 32'sd1;
    endfunction

endpackage

// File: rtl/step_capture_sync_filter.sv
// Two-flop synchronizer with an optional persistence filter.
// Reports accepted level changes and rejected short transitions.
module sync_filter
    import step_capture_pkg::*;
#(
    parameter int   FILTER_LEN = 4,
    parameter bit   BYPASS     = 1'b0,
    parameter logic RESET_VAL  = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall,
    output logic glitch
);

    localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

    logic s1;
    logic s2;

    // Metastability guard for the asynchronous pin
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= RESET_VAL;
            s2 <= RESET_VAL;
        end else begin
            s1 <= pin;
            s2 <= s1;
        end
    end

    if (BYPASS) begin : g_bypass
        assign level  = s2;
        assign rise   = 1'b0;
        assign fall   = 1'b0;
        assign glitch = 1'b0;
    end else begin : g_filter
        logic [0:0]    state;
        logic [FW-1:0] fcnt;
        logic          differ;
        logic          flip;

        assign differ = (s2 != state[0]);
        assign flip   = differ && (fcnt == FW'(FILTER_LEN - 1));

        // Accept a new level only after it persists FILTER_LEN cycles
        always_ff @(posedge clk) begin
            if (reset) begin
                state <= RESET_VAL ? FILT_HIGH : FILT_LOW;
                fcnt  <= '0;
            end else if (flip) begin
                state <= s2 ? FILT_HIGH : FILT_LOW;
                fcnt  <= '0;
            end else if (differ) begin
                fcnt  <= fcnt + 1'b1;
            end else if (fcnt != '0) begin
                fcnt  <= '0;
            end
        end

        assign level  = (state == FILT_HIGH);
        assign rise   = flip && s2;
        assign fall   = flip && !s2;
        assign glitch = !differ && (fcnt != '0);
    end

endmodule

// File: rtl/step_capture.sv
// Step/dir receiver: decodes a filtered step stream into a signed
// position, measures the step period and flags timing violations.
module step_capture
    import step_capture_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int DIR_SETUP  = 16,
    parameter int PERIOD_W   = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                step_in,
    input  logic                dir_in,
    input  logic                set_position,
    input  logic signed [31:0]  data_in,
    input  logic                clear_err,
    output logic signed [31:0]  position,
    output logic                step_strobe,
    output logic                step_dir,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                stalled,
    output logic                dir_err,
    output logic                glitch_err
);

    localparam int DW = $clog2(DIR_SETUP + 1);
    localparam logic [PERIOD_W-1:0] PMAX = '1;

    logic                step_rise;
    logic                step_glitch;
    logic                step_unused_level;
    logic                step_unused_fall;
    logic                dir_s2;
    logic                dir_unused_rise;
    logic                dir_unused_fall;
    logic                dir_unused_glitch;
    logic                dir_last;
    logic [DW-1:0]       dir_stable;
    logic [PERIOD_W-1:0] pcnt;
    logic                have_step;
    logic                step_event;

    sync_filter #(
        .FILTER_LEN (FILTER_LEN),
        .BYPASS     (1'b0),
        .RESET_VAL  (1'b1)
    ) u_step (
        .clk    (clk),
        .reset  (reset),
        .pin    (step_in),
        .level  (step_unused_level),
        .rise   (step_rise),
        .fall   (step_unused_fall),
        .glitch (step_glitch)
    );

    sync_filter #(
        .FILTER_LEN (FILTER_LEN),
        .BYPASS     (1'b1),
        .RESET_VAL  (1'b0)
    ) u_dir (
        .clk    (clk),
        .reset  (reset),
        .pin    (dir_in),
        .level  (dir_s2),
        .rise   (dir_unused_rise),
        .fall   (dir_unused_fall),
        .glitch (dir_unused_glitch)
    );

    // A load request swallows a coincident step
    assign step_event = step_rise && !set_position;
    assign stalled    = (pcnt == PMAX);

    // Age of the current dir level, saturating at the setup window
    always_ff @(posedge clk) begin
        if (reset) begin
            dir_last   <= 1'b0;
            dir_stable <= '0;
        end else if (dir_s2 != dir_last) begin
            dir_last   <= dir_s2;
            dir_stable <= '0;
        end else if (dir_stable < DW'(DIR_SETUP)) begin
            dir_stable <= dir_stable + 1'b1;
        end
    end

    // Position accumulation and per-step outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            position    <= '0;
            step_strobe <= 1'b0;
            step_dir    <= 1'b0;
        end else begin
            step_strobe <= step_event;
            if (set_position) begin
                position <= data_in;
            end else if (step_event) begin
                position <= position + step_delta(dir_s2);
                step_dir <= dir_s2;
            end
        end
    end

    // Sticky error flags; a new error beats a clear
    always_ff @(posedge clk) begin
        if (reset) begin
            dir_err    <= 1'b0;
            glitch_err <= 1'b0;
        end else begin
            if (step_event && (dir_stable < DW'(DIR_SETUP)))
                dir_err <= 1'b1;
            else if (clear_err)
                dir_err <= 1'b0;
            if (step_glitch)
                glitch_err <= 1'b1;
            else if (clear_err)
                glitch_err <= 1'b0;
        end
    end

    // Step-to-step period measurement with stall detection
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt         <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            have_step    <= 1'b0;
        end else if (set_position) begin
            pcnt         <= '0;
            period_valid <= 1'b0;
            have_step    <= 1'b0;
        end else if (step_event) begin
            period       <= stalled ? PMAX : pcnt + 1'b1;
            pcnt         <= '0;
            period_valid <= have_step;
            have_step    <= 1'b1;
        end else if (stalled) begin
            period_valid <= 1'b0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_step_capture.sv
// Directed bench for step_capture: table of pulse patterns plus
// hand sequences for latency, period, dir setup, stall and load.
module tb_step_capture;

    logic               clk = 1'b0;
    logic               reset;
    logic               step_in;
    logic               dir_in;
    logic               set_position;
    logic signed [31:0] data_in;
    logic               clear_err;

    logic signed [31:0] position;
    logic               step_strobe;
    logic               step_dir;
    logic [23:0]        period;
    logic               period_valid;
    logic               stalled;
    logic               dir_err;
    logic               glitch_err;

    logic signed [31:0] position8;
    logic               step_strobe8;
    logic               step_dir8;
    logic [7:0]         period8;
    logic               period_valid8;
    logic               stalled8;
    logic               dir_err8;
    logic               glitch_err8;

    int tests = 0;
    int failed = 0;
    int strobe_cnt = 0;

    always #5 clk = ~clk;

    step_capture dut (
        .clk          (clk),
        .reset        (reset),
        .step_in      (step_in),
        .dir_in       (dir_in),
        .set_position (set_position),
        .data_in      (data_in),
        .clear_err    (clear_err),
        .position     (position),
        .step_strobe  (step_strobe),
        .step_dir     (step_dir),
        .period       (period),
        .period_valid (period_valid),
        .stalled      (stalled),
        .dir_err      (dir_err),
        .glitch_err   (glitch_err)
    );

    step_capture #(.PERIOD_W(8)) dut8 (
        .clk          (clk),
        .reset        (reset),
        .step_in      (step_in),
        .dir_in       (dir_in),
        .set_position (set_position),
        .data_in      (data_in),
        .clear_err    (clear_err),
        .position     (position8),
        .step_strobe  (step_strobe8),
        .step_dir     (step_dir8),
        .period       (period8),
        .period_valid (period_valid8),
        .stalled      (stalled8),
        .dir_err      (dir_err8),
        .glitch_err   (glitch_err8)
    );

    always @(posedge clk) begin
        if (reset)
            strobe_cnt <= 0;
        else if (step_strobe)
            strobe_cnt <= strobe_cnt + 1;
    end

    typedef struct {
        logic dir;
        int   hi;
        int   lo;
        int   n;
        int   exp_pos;
        logic exp_glitch;
        logic exp_sdir;
    } vec_t;

    vec_t vecs[6];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, $signed(act), act, $signed(exp), exp);
        end
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
    endtask

    initial begin
        int lat;
        int sc;

        vecs[0] = '{1'b0, 4, 4,  2,  2, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 3, 8,  1,  2, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 6, 6,  3, -1, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1, 5,  1, -1, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 10, 10, 2,  1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 4, 3,  2,  0, 1'b1, 1'b1};

        reset        = 1'b1;
        step_in      = 1'b1;
        dir_in       = 1'b0;
        set_position = 1'b0;
        data_in      = '0;
        clear_err    = 1'b0;
        tick(3);
        check("rst_position", position, 0);
        check("rst_strobe", {31'd0, step_strobe}, 0);
        check("rst_period", {8'd0, period}, 0);
        check("rst_pvalid", {31'd0, period_valid}, 0);
        check("rst_stalled", {31'd0, stalled}, 0);
        check("rst_errs", {30'd0, dir_err, glitch_err}, 0);
        reset = 1'b0;

        // line high at reset release must not count
        tick(50);
        check("hi_at_reset_strobes", strobe_cnt, 0);
        check("hi_at_reset_pos", position, 0);

        // falling edge has no effect, then measure rise latency
        step_in = 1'b0;
        tick(40);
        check("fall_no_strobe", strobe_cnt, 0);
        step_in = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (step_strobe && lat == 0) lat = i;
        end
        check("rise_latency", lat, 6);
        check("first_step_pos", position, 1);
        check("first_step_dir", {31'd0, step_dir}, 0);
        check("first_step_cnt", strobe_cnt, 1);
        step_in = 1'b0;
        tick(10);

        // three steps 300 cycles apart, negative direction
        set_position = 1'b1;
        data_in      = 0;
        tick(1);
        set_position = 1'b0;
        dir_in = 1'b1;
        tick(40);
        for (int s = 0; s < 3; s++) begin
            step_in = 1'b1;
            tick(10);
            step_in = 1'b0;
            tick(290);
            if (s == 0)
                check("pvalid_after_1", {31'd0, period_valid}, 0);
            if (s == 1) begin
                check("pvalid_after_2", {31'd0, period_valid}, 1);
                check("period_300", {8'd0, period}, 300);
            end
        end
        check("three_neg_pos", position, -3);
        check("three_neg_dir", {31'd0, step_dir}, 1);
        check("three_neg_period", {8'd0, period}, 300);
        check("three_neg_direrr", {31'd0, dir_err}, 0);

        // table of pulse patterns
        set_position = 1'b1;
        data_in      = 0;
        tick(1);
        set_position = 1'b0;
        for (int v = 0; v < 6; v++) begin
            dir_in = vecs[v].dir;
            pulse_clear();
            tick(20);
            for (int p = 0; p < vecs[v].n; p++) begin
                step_in = 1'b1;
                tick(vecs[v].hi);
                step_in = 1'b0;
                tick(vecs[v].lo);
            end
            tick(8);
            check($sformatf("vec%0d_pos", v), position, vecs[v].exp_pos);
            check($sformatf("vec%0d_glitch", v),
                  {31'd0, glitch_err}, {31'd0, vecs[v].exp_glitch});
            check($sformatf("vec%0d_sdir", v),
                  {31'd0, step_dir}, {31'd0, vecs[v].exp_sdir});
        end

        // short pulse: rejected, sticky glitch, then cleared
        pulse_clear();
        check("glitch_cleared0", {31'd0, glitch_err}, 0);
        step_in = 1'b1;
        tick(2);
        step_in = 1'b0;
        tick(10);
        check("glitch_set", {31'd0, glitch_err}, 1);
        check("glitch_pos", position, 0);
        pulse_clear();
        check("glitch_clear", {31'd0, glitch_err}, 0);

        // dir changes just before the accepted edge
        dir_in = 1'b0;
        tick(30);
        pulse_clear();
        step_in = 1'b1;
        dir_in  = 1'b1;
        tick(12);
        step_in = 1'b0;
        tick(10);
        check("dirsetup_pos", position, -1);
        check("dirsetup_sdir", {31'd0, step_dir}, 1);
        check("dirsetup_err", {31'd0, dir_err}, 1);
        pulse_clear();
        check("dirsetup_clear", {31'd0, dir_err}, 0);

        // quiet line saturates the narrow period counter
        tick(300);
        check("stall8", {31'd0, stalled8}, 1);
        check("stall8_pvalid", {31'd0, period_valid8}, 0);
        check("nostall24", {31'd0, stalled}, 0);
        check("nostall24_pvalid", {31'd0, period_valid}, 1);

        // load coincident with a step event drops the step
        sc = strobe_cnt;
        dir_in  = 1'b0;
        step_in = 1'b1;
        tick(5);
        set_position = 1'b1;
        data_in      = 1000;
        tick(1);
        set_position = 1'b0;
        check("load_strobe", {31'd0, step_strobe}, 0);
        check("load_pos", position, 1000);
        tick(15);
        check("load_pos_hold", position, 1000);
        check("load_no_strobe", strobe_cnt, sc);
        check("load_no_direrr", {31'd0, dir_err}, 0);
        check("load_pvalid", {31'd0, period_valid}, 0);
        check("load_unstall8", {31'd0, stalled8}, 0);
        check("load_pos8", position8, 1000);
        step_in = 1'b0;
        tick(10);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
